// File: rtl/axi4s_overwrite_bytes.sv
// Overwrites the first OVR_BYTES bytes of each AXI4-Stream packet with a per-packet header.
// Optional nonzero-byte check in the header region: define AXI4S_OVERWRITE_BYTES_CHECK_EN.
module axi4s_overwrite_bytes #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4,
    parameter int OVR_BYTES  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [USER_WIDTH-1:0]   i_tuser,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic [OVR_BYTES*8-1:0]  hdr_tdata,
    input  logic                    hdr_tvalid,
    output logic                    hdr_tready,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic [USER_WIDTH-1:0]   o_tuser,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int PW  = $clog2(OVR_BYTES + 1) + 1;

    typedef enum logic [1:0] {ST_FIRST, ST_HDR, ST_PASS} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          pos, pos_nxt;
    logic                   err_q;
    logic [OVR_BYTES*8-1:0] hdr_q, hdr_src;
    logic                   accept;
    logic                   in_err, short_err, chk_err, word_err;
    logic [USER_WIDTH-2:0]  in_bytes;
    int                     vbytes;
    logic [DATA_WIDTH-1:0]  ovr_data;

    // tuser carries the error flag in its MSB and the byte count below it
    assign in_err   = i_tuser[USER_WIDTH-1];
    assign in_bytes = i_tuser[USER_WIDTH-2:0];
    assign vbytes   = (in_bytes == '0) ? BPW : int'(in_bytes);

    assign i_tready   = rst_n & (!o_tvalid | o_tready) & ((state != ST_FIRST) | hdr_tvalid);
    assign accept     = i_tvalid & i_tready;
    assign hdr_tready = accept & (state == ST_FIRST);
    assign hdr_src    = (state == ST_FIRST) ? hdr_tdata : hdr_q;

    always_comb begin
        ovr_data = i_tdata;
        for (int j = 0; j < BPW; j++) begin
            if ((int'(pos) + j < OVR_BYTES) && (j < vbytes))
                ovr_data[8*j +: 8] = hdr_src[8*(int'(pos) + j) +: 8];
        end
    end

`ifdef AXI4S_OVERWRITE_BYTES_CHECK_EN
    always_comb begin
        chk_err = 1'b0;
        for (int j = 0; j < BPW; j++) begin
            if ((int'(pos) + j < OVR_BYTES) && (j < vbytes) && (i_tdata[8*j +: 8] != 8'h00))
                chk_err = 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    // A packet ending before the header region is filled drops the remaining header bytes
    assign short_err = i_tlast & (int'(pos) + vbytes < OVR_BYTES);
    assign word_err  = in_err | err_q | short_err | chk_err;

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        if (accept) begin
            if (i_tlast)
                pos_nxt = '0;
            else if (int'(pos) + BPW >= OVR_BYTES)
                pos_nxt = PW'(OVR_BYTES);
            else
                pos_nxt = pos + PW'(BPW);

            case (state)
                ST_FIRST: begin
                    if (i_tlast)               state_nxt = ST_FIRST;
                    else if (BPW >= OVR_BYTES) state_nxt = ST_PASS;
                    else                       state_nxt = ST_HDR;
                end
                ST_HDR: begin
                    if (i_tlast)                             state_nxt = ST_FIRST;
                    else if (int'(pos) + BPW >= OVR_BYTES)   state_nxt = ST_PASS;
                end
                ST_PASS: begin
                    if (i_tlast) state_nxt = ST_FIRST;
                end
                default: state_nxt = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
            pos   <= '0;
            err_q <= 1'b0;
            hdr_q <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            if (hdr_tready)
                hdr_q <= hdr_tdata;
            if (accept)
                err_q <= i_tlast ? 1'b0 : word_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tuser  <= '0;
            o_tlast  <= 1'b0;
        end else if (accept) begin
            o_tvalid <= 1'b1;
            o_tdata  <= ovr_data;
            o_tuser  <= {word_err, in_bytes};
            o_tlast  <= i_tlast;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4s_overwrite_bytes.sv
// Directed scoreboard bench for axi4s_overwrite_bytes (32-bit data, 6 header bytes).
module tb_axi4s_overwrite_bytes;
    localparam int DW  = 32;
    localparam int UW  = 4;
    localparam int OVR = 6;
    localparam int BPW = DW / 8;
`ifdef AXI4S_OVERWRITE_BYTES_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   i_tdata;
    logic [UW-1:0]   i_tuser;
    logic            i_tlast, i_tvalid, i_tready;
    logic [OVR*8-1:0] hdr_tdata;
    logic            hdr_tvalid, hdr_tready;
    logic [DW-1:0]   o_tdata;
    logic [UW-1:0]   o_tuser;
    logic            o_tlast, o_tvalid, o_tready;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    int   hdr_pulses  = 0;
    int   run_len     = 0;
    int   max_run     = 0;
    bit   toggle_en   = 1'b0;

    axi4s_overwrite_bytes #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .OVR_BYTES(OVR)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .hdr_tdata(hdr_tdata), .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        assert (act === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs are compared on the falling edge, when a handshake is guaranteed for the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                check_output("output_without_expected", o_tvalid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_output("o_tdata", o_tdata, e.data);
                check_output("o_tuser", o_tuser, e.user);
                check_output("o_tlast", o_tlast, e.last);
            end
        end
        if (hdr_tready) hdr_pulses++;
        run_len = o_tvalid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    end

    always @(posedge clk) begin
        #1;
        if (toggle_en) o_tready = ~o_tready;
    end

    task automatic drive_word(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l,
                              output int waited);
        logic acc;
        i_tdata = d; i_tuser = u; i_tlast = l; i_tvalid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            acc = i_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check_output("accept_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        i_tvalid = 1'b0;
    endtask

    // Byte-level packet model: header fills packet bytes 0..OVR-1 that are actually present
    task automatic apply_stimulus(input logic [OVR*8-1:0] hdr, input logic [3:0][DW-1:0] words,
                                  input int n, input int last_bytes, input logic [3:0] err_in,
                                  output int first_wait);
        int            bi, vb, waited;
        logic          acc_err, werr, last;
        logic [DW-1:0] ed;
        logic [2:0]    bf;
        exp_t          e;
        bi = 0; acc_err = 1'b0; first_wait = 0;
        for (int w = 0; w < n; w++) begin
            last = (w == n - 1);
            bf   = last ? 3'(last_bytes) : 3'd0;
            vb   = (bf == 3'd0) ? BPW : int'(bf);
            ed   = words[w];
            werr = err_in[w];
            for (int j = 0; j < vb; j++) begin
                if (bi + j < OVR) begin
                    if (CHECK_EN && words[w][8*j +: 8] != 8'h00) werr = 1'b1;
                    ed[8*j +: 8] = hdr[8*(bi + j) +: 8];
                end
            end
            if (last && bi + vb < OVR) werr = 1'b1;
            acc_err |= werr;
            e.data = ed; e.user = {acc_err, bf}; e.last = last;
            exp_q.push_back(e);
            bi += vb;
        end
        hdr_tdata = hdr; hdr_tvalid = 1'b1;
        for (int w = 0; w < n; w++) begin
            drive_word(words[w], {err_in[w], (w == n - 1) ? 3'(last_bytes) : 3'd0}, w == n - 1, waited);
            if (w == 0) first_wait = waited;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || o_tvalid) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [3:0][DW-1:0] pkt;
        int                 fw, p0, waited;

        rst_n = 1'b0; i_tdata = '0; i_tuser = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        hdr_tdata = '0; hdr_tvalid = 1'b0; o_tready = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_o_tvalid", o_tvalid, 1'b0);
        check_output("reset_o_tdata", o_tdata, '0);
        check_output("reset_o_tuser", o_tuser, '0);
        check_output("reset_o_tlast", o_tlast, 1'b0);
        check_output("reset_hdr_tready", hdr_tready, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic 3-word packet");
        p0 = hdr_pulses;
        pkt = {32'h0, 32'h12345678, 32'hDDCC0000, 32'h00000000};
        apply_stimulus(48'h665544332211, pkt, 3, 0, 4'b0, fw);
        wait_drain();
        check_output("basic_hdr_pulses", 64'(hdr_pulses - p0), 64'd1);

        $display("[TB] header arrives late");
        hdr_tvalid = 1'b0; i_tdata = '0; i_tuser = '0; i_tlast = 1'b1; i_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("wait_i_tready", i_tready, 1'b0);
            check_output("wait_o_tvalid", o_tvalid, 1'b0);
        end
        @(posedge clk); #1;
        pkt = '0;
        apply_stimulus(48'h665544332211, pkt, 1, 0, 4'b0, fw);
        check_output("late_hdr_wait", 64'(fw), 64'd0);
        check_output("late_hdr_o_tvalid", o_tvalid, 1'b1);
        wait_drain();

        $display("[TB] back-to-back packets");
        p0 = hdr_pulses;
        max_run = 0;
        for (int p = 0; p < 4; p++) begin
            pkt = {32'h0, 32'h0, $urandom & 32'hFFFF0000, 32'h0};
            apply_stimulus(48'h1F1E1D1C1B10 + 48'(p), pkt, 2, 0, 4'b0, fw);
        end
        wait_drain();
        check_output("b2b_max_run", 64'(max_run), 64'd8);
        check_output("b2b_hdr_pulses", 64'(hdr_pulses - p0), 64'd4);

        $display("[TB] short packet");
        pkt = {32'h0, 32'h0, 32'h0, 32'hFFEE0000};
        apply_stimulus(48'h665544332211, pkt, 1, 2, 4'b0, fw);
        pkt = {32'h0, 32'h12345678, 32'hDDCC0000, 32'h00000000};
        apply_stimulus(48'hA5A4A3A2A1A0, pkt, 3, 0, 4'b0, fw);
        wait_drain();

        $display("[TB] output backpressure");
        toggle_en = 1'b1;
        pkt = {32'h0, 32'h12345678, 32'hDDCC0000, 32'h00000000};
        apply_stimulus(48'h665544332211, pkt, 3, 0, 4'b0, fw);
        wait_drain();
        toggle_en = 1'b0;
        o_tready = 1'b1;

        $display("[TB] nonzero byte in header region");
        pkt = {32'h0, 32'h12345678, 32'hDDCC0000, 32'h7F000000};
        apply_stimulus(48'h665544332211, pkt, 3, 0, 4'b0, fw);
        wait_drain();

        $display("[TB] input error propagation");
        pkt = {32'h0, 32'h0BADF00D, 32'h55AA0000, 32'h00000000};
        apply_stimulus(48'h0C0B0A090807, pkt, 3, 3, 4'b0010, fw);
        wait_drain();

        $display("[TB] reset mid-packet");
        hdr_tdata = 48'h665544332211; hdr_tvalid = 1'b1;
        drive_word(32'h0, 4'h0, 1'b0, waited);
        i_tdata = 32'hDDCC0000; i_tuser = '0; i_tlast = 1'b0; i_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_o_tvalid", o_tvalid, 1'b0);
        check_output("midrst_o_tdata", o_tdata, '0);
        check_output("midrst_o_tuser", o_tuser, '0);
        check_output("midrst_o_tlast", o_tlast, 1'b0);
        check_output("midrst_hdr_tready", hdr_tready, 1'b0);
        i_tvalid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        p0 = hdr_pulses;
        pkt = {32'h0, 32'h12345678, 32'hDDCC0000, 32'h00000000};
        apply_stimulus(48'h0F0E0D0C0B0A, pkt, 3, 0, 4'b0, fw);
        wait_drain();
        check_output("postrst_hdr_pulses", 64'(hdr_pulses - p0), 64'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
